// File: rtl/cmac_axi_2_lbus_aligned.sv
// AXI4-Stream (512b) to CMAC LBUS TX adapter: byte reversal, TLAST/TSTRB to
// EN/SOP/EOP/MTY/ERR, 2-entry skid buffer for tx_rdy backpressure, status.
module cmac_axi_2_lbus_aligned #(
    parameter int unsigned C_TRANSMISSION_SEGMENTS = 4,
    parameter int unsigned C_DATA_WIDTH            = 512
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 AXI2LBUS_TVALID,
    input  logic                                 AXI2LBUS_TLAST,
    input  logic [C_DATA_WIDTH/8-1:0]            AXI2LBUS_TSTRB,
    input  logic [C_DATA_WIDTH-1:0]              AXI2LBUS_TDATA,
    output logic                                 AXI2LBUS_TREADY,
    output logic [C_TRANSMISSION_SEGMENTS-1:0]   CMAC_LBUS_TX_EN,
    output logic [C_TRANSMISSION_SEGMENTS-1:0]   CMAC_LBUS_TX_SOP,
    output logic [C_TRANSMISSION_SEGMENTS-1:0]   CMAC_LBUS_TX_EOP,
    output logic [4*C_TRANSMISSION_SEGMENTS-1:0] CMAC_LBUS_TX_MTY,
    output logic [C_TRANSMISSION_SEGMENTS-1:0]   CMAC_LBUS_TX_ERR,
    output logic [C_DATA_WIDTH-1:0]              CMAC_LBUS_TX_DATA,
    input  logic                                 CMAC_LBUS_TX_RDY,
    input  logic                                 CMAC_LBUS_TX_OVFOUT,
    input  logic                                 CMAC_LBUS_TX_UNFOUT,
    output logic [31:0]                          PKT_CNT,
    output logic [15:0]                          BUBBLE_CNT,
    output logic                                 OVF_STICKY,
    output logic                                 UNF_STICKY,
    output logic                                 PROTO_ERR_STICKY
);

    localparam int unsigned SEGS      = C_TRANSMISSION_SEGMENTS;
    localparam int unsigned BYTES     = C_DATA_WIDTH / 8;
    localparam int unsigned SEG_BYTES = BYTES / SEGS;
    localparam int unsigned IDX_W     = $clog2(BYTES);
    localparam int unsigned CNT_W     = IDX_W + 1;
    localparam int unsigned SEG_W     = $clog2(SEGS) + 1;
    localparam int unsigned SEG_SHIFT = $clog2(SEG_BYTES);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t state_q, state_d;

    logic [C_DATA_WIDTH-1:0] buf_data [2];
    logic [BYTES-1:0]        buf_strb [2];
    logic                    buf_last [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    logic                    up_q;
    logic                    push, pop;

    logic [C_DATA_WIDTH-1:0] head_data, data_rev;
    logic [BYTES-1:0]        head_strb, mask;
    logic                    head_last;
    logic [IDX_W-1:0]        hi;
    logic [CNT_W-1:0]        n;
    logic [SEG_W-1:0]        s;
    logic [3:0]              mty_val;
    logic                    bad_last;

    logic [SEGS-1:0]         en_d, sop_d, eop_d, err_d;
    logic [4*SEGS-1:0]       mty_d;
    logic                    proto_d, eop_pop, bubble;

    assign AXI2LBUS_TREADY = up_q && (count != 2'd2);
    assign push            = AXI2LBUS_TVALID && AXI2LBUS_TREADY;
    assign pop             = (count != 2'd0) && CMAC_LBUS_TX_RDY;

    assign head_data = buf_data[rd_ptr];
    assign head_strb = buf_strb[rd_ptr];
    assign head_last = buf_last[rd_ptr];

    // Skid buffer storage; only the written slot changes.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_data[wr_ptr] <= AXI2LBUS_TDATA;
            buf_strb[wr_ptr] <= AXI2LBUS_TSTRB;
            buf_last[wr_ptr] <= AXI2LBUS_TLAST;
        end
    end

    // Skid buffer pointers, occupancy and post-reset ready enable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            up_q   <= 1'b0;
        end else begin
            up_q <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // Head-of-buffer decode: byte count, segment count, contiguity, byte reversal.
    always_comb begin
        hi = '0;
        for (int unsigned j = 0; j < BYTES; j++) begin
            if (head_strb[j]) hi = IDX_W'(j);
        end
        n        = CNT_W'(hi) + CNT_W'(1);
        s        = SEG_W'((n + CNT_W'(SEG_BYTES - 1)) >> SEG_SHIFT);
        mty_val  = 4'((CNT_W'(s) << SEG_SHIFT) - n);
        mask     = {BYTES{1'b1}} >> (CNT_W'(BYTES) - n);
        bad_last = (head_strb != mask);
        data_rev = '0;
        for (int unsigned j = 0; j < BYTES; j++) begin
            data_rev[C_DATA_WIDTH-8*(j+1) +: 8] = head_data[8*j +: 8];
        end
    end

    // Packet FSM next state and next LBUS control word.
    always_comb begin
        state_d = state_q;
        en_d    = '0;
        sop_d   = '0;
        eop_d   = '0;
        err_d   = '0;
        mty_d   = '0;
        proto_d = 1'b0;
        eop_pop = 1'b0;
        bubble  = 1'b0;
        if (pop) begin
            if (state_q == IDLE) sop_d = SEGS'(1);
            if (head_last) begin
                state_d = IDLE;
                eop_pop = 1'b1;
                proto_d = bad_last;
                for (int unsigned i = 0; i < SEGS; i++) begin
                    if (SEG_W'(i) < s) en_d[i] = 1'b1;
                    if (SEG_W'(i + 1) == s) begin
                        eop_d[i]       = 1'b1;
                        err_d[i]       = bad_last;
                        mty_d[4*i +: 4] = mty_val;
                    end
                end
            end else begin
                state_d = IN_PKT;
                en_d    = '1;
                proto_d = (head_strb != '1);
            end
        end else if (state_q == IN_PKT && CMAC_LBUS_TX_RDY) begin
            bubble = 1'b1;
        end
    end

    // Packet FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered LBUS outputs, counters and sticky flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CMAC_LBUS_TX_EN   <= '0;
            CMAC_LBUS_TX_SOP  <= '0;
            CMAC_LBUS_TX_EOP  <= '0;
            CMAC_LBUS_TX_MTY  <= '0;
            CMAC_LBUS_TX_ERR  <= '0;
            CMAC_LBUS_TX_DATA <= '0;
            PKT_CNT           <= '0;
            BUBBLE_CNT        <= '0;
            OVF_STICKY        <= 1'b0;
            UNF_STICKY        <= 1'b0;
            PROTO_ERR_STICKY  <= 1'b0;
        end else begin
            CMAC_LBUS_TX_EN  <= en_d;
            CMAC_LBUS_TX_SOP <= sop_d;
            CMAC_LBUS_TX_EOP <= eop_d;
            CMAC_LBUS_TX_MTY <= mty_d;
            CMAC_LBUS_TX_ERR <= err_d;
            if (pop)     CMAC_LBUS_TX_DATA <= data_rev;
            if (eop_pop) PKT_CNT <= PKT_CNT + 32'd1;
            if (bubble && BUBBLE_CNT != 16'hFFFF) BUBBLE_CNT <= BUBBLE_CNT + 16'd1;
            if (CMAC_LBUS_TX_OVFOUT) OVF_STICKY <= 1'b1;
            if (CMAC_LBUS_TX_UNFOUT) UNF_STICKY <= 1'b1;
            if (proto_d) PROTO_ERR_STICKY <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmac_axi_2_lbus_aligned.sv
// Bench for cmac_axi_2_lbus_aligned: constant vector table, directed corner
// sequences, and random traffic against a queue-based reference model.
module tb_cmac_axi_2_lbus_aligned;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         TVALID = 1'b0;
    logic         TLAST = 1'b0;
    logic [63:0]  TSTRB = '0;
    logic [511:0] TDATA = '0;
    logic         TREADY;
    logic [3:0]   EN, SOP, EOP, ERR;
    logic [15:0]  MTY;
    logic [511:0] DATA;
    logic         RDY = 1'b1;
    logic         OVF = 1'b0;
    logic         UNF = 1'b0;
    logic [31:0]  PKT_CNT;
    logic [15:0]  BUBBLE_CNT;
    logic         OVF_STICKY, UNF_STICKY, PROTO_ERR_STICKY;

    cmac_axi_2_lbus_aligned #(.C_TRANSMISSION_SEGMENTS(4), .C_DATA_WIDTH(512)) dut (
        .CLK(CLK), .RST(RST),
        .AXI2LBUS_TVALID(TVALID), .AXI2LBUS_TLAST(TLAST), .AXI2LBUS_TSTRB(TSTRB),
        .AXI2LBUS_TDATA(TDATA), .AXI2LBUS_TREADY(TREADY),
        .CMAC_LBUS_TX_EN(EN), .CMAC_LBUS_TX_SOP(SOP), .CMAC_LBUS_TX_EOP(EOP),
        .CMAC_LBUS_TX_MTY(MTY), .CMAC_LBUS_TX_ERR(ERR), .CMAC_LBUS_TX_DATA(DATA),
        .CMAC_LBUS_TX_RDY(RDY), .CMAC_LBUS_TX_OVFOUT(OVF), .CMAC_LBUS_TX_UNFOUT(UNF),
        .PKT_CNT(PKT_CNT), .BUBBLE_CNT(BUBBLE_CNT), .OVF_STICKY(OVF_STICKY),
        .UNF_STICKY(UNF_STICKY), .PROTO_ERR_STICKY(PROTO_ERR_STICKY)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;

    function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected LBUS control word for one beat, from byte counts.
    function automatic void lbus_of(input logic [63:0] strb, input logic last,
                                    output logic [3:0] en, output logic [3:0] eop,
                                    output logic [15:0] mty, output logic [3:0] err,
                                    output logic bad);
        int nb, s;
        en = 4'h0; eop = 4'h0; mty = 16'h0; err = 4'h0; bad = 1'b0;
        if (!last) begin
            en  = 4'hF;
            bad = (strb != 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            nb = 0;
            for (int j = 0; j < 64; j++) if (strb[j]) nb = j + 1;
            if (nb == 0) begin
                en = 4'h1; eop = 4'h1; mty = 16'h000F; err = 4'h1; bad = 1'b1;
            end else begin
                s   = (nb + 15) / 16;
                en  = 4'((1 << s) - 1);
                eop = 4'(1 << (s - 1));
                mty = 16'((16 * s - nb) << (4 * (s - 1)));
                bad = ($countones(strb) != nb);
                err = bad ? eop : 4'h0;
            end
        end
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // Reference model: accepted-but-not-issued beats and expected registered outputs.
    typedef struct {
        logic [511:0] data;
        logic [63:0]  strb;
        logic         last;
    } beat_t;

    beat_t        m_q[$];
    logic         m_in_pkt = 1'b0, m_up = 1'b0;
    logic [3:0]   m_en = 0, m_sop = 0, m_eop = 0, m_err = 0;
    logic [15:0]  m_mty = 0, m_bub = 0;
    logic [511:0] m_data = '0;
    logic [31:0]  m_pkt = 0;
    logic         m_ovf = 0, m_unf = 0, m_proto = 0;

    always @(negedge CLK) begin
        beat_t b;
        logic  bad;
        if (RST) begin
            m_q.delete();
            m_in_pkt = 0; m_up = 0;
            m_en = 0; m_sop = 0; m_eop = 0; m_err = 0; m_mty = 0; m_bub = 0;
            m_data = '0; m_pkt = 0; m_ovf = 0; m_unf = 0; m_proto = 0;
        end
        chk("mon_en", 512'(EN), 512'(m_en));
        chk("mon_sop", 512'(SOP), 512'(m_sop));
        chk("mon_eop", 512'(EOP), 512'(m_eop));
        chk("mon_mty", 512'(MTY), 512'(m_mty));
        chk("mon_err", 512'(ERR), 512'(m_err));
        chk("mon_data", DATA, m_data);
        chk("mon_pkt_cnt", 512'(PKT_CNT), 512'(m_pkt));
        chk("mon_bubble_cnt", 512'(BUBBLE_CNT), 512'(m_bub));
        chk("mon_stickies", 512'({OVF_STICKY, UNF_STICKY, PROTO_ERR_STICKY}),
            512'({m_ovf, m_unf, m_proto}));
        chk("mon_tready", 512'(TREADY), 512'(m_up && (m_q.size() < 2)));
        if (!RST) begin
            m_en = 0; m_sop = 0; m_eop = 0; m_err = 0; m_mty = 0;
            if (RDY && m_q.size() > 0) begin
                b = m_q.pop_front();
                lbus_of(b.strb, b.last, m_en, m_eop, m_mty, m_err, bad);
                m_sop    = m_in_pkt ? 4'h0 : 4'h1;
                m_in_pkt = !b.last;
                m_data   = {<<8{b.data}};
                if (b.last) m_pkt = m_pkt + 1;
                if (bad) m_proto = 1;
            end else if (RDY && m_in_pkt && m_bub != 16'hFFFF) begin
                m_bub = m_bub + 1;
            end
            if (OVF) m_ovf = 1;
            if (UNF) m_unf = 1;
            if (TVALID && TREADY) m_q.push_back('{TDATA, TSTRB, TLAST});
            m_up = 1;
        end
    end

    logic [511:0] last_data;

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [63:0] strb, input logic last);
        logic got;
        got       = 1'b0;
        last_data = rand512();
        TVALID = 1'b1; TLAST = last; TSTRB = strb; TDATA = last_data;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge CLK); got = TREADY;
            @(posedge CLK); #1;
        end
        chk("send_accepted", 512'(got), 512'(1));
        TVALID = 1'b0;
    endtask

    typedef struct {
        logic [63:0] strb;
        logic [3:0]  en, eop;
        logic [15:0] mty;
        logic [3:0]  err;
        logic        proto;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'h8, 16'h0000, 4'h0, 1'b0};
        tbl[1] = '{64'h0000_0000_0000_00F1, 4'h1, 4'h1, 16'h0008, 4'h1, 1'b1};
        tbl[2] = '{64'h0000_0000_0000_0000, 4'h1, 4'h1, 16'h000F, 4'h1, 1'b1};
        tbl[3] = '{64'h0000_0000_003F_FFFF, 4'h3, 4'h2, 16'h00A0, 4'h0, 1'b1};
        tbl[4] = '{64'h0000_FFFF_FFFF_FFFF, 4'h7, 4'h4, 16'h0000, 4'h0, 1'b1};
        tbl[5] = '{64'h0000_0000_0000_0001, 4'h1, 4'h1, 16'h000F, 4'h0, 1'b1};
        tbl[6] = '{64'h8000_0000_0000_0000, 4'hF, 4'h8, 16'h0000, 4'h8, 1'b1};
        tbl[7] = '{64'h0001_FFFF_FFFF_FFFF, 4'hF, 4'h8, 16'hF000, 4'h0, 1'b1};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_en", 512'(EN), 512'(0));
        chk("reset_tready", 512'(TREADY), 512'(0));
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("tready_after_reset", 512'(TREADY), 512'(1));

        // Single-beat packets from the constant table.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].strb, 1'b1);
            @(posedge CLK); #1;
            chk("tbl_en", 512'(EN), 512'(tbl[i].en));
            chk("tbl_sop", 512'(SOP), 512'(4'h1));
            chk("tbl_eop", 512'(EOP), 512'(tbl[i].eop));
            chk("tbl_mty", 512'(MTY), 512'(tbl[i].mty));
            chk("tbl_err", 512'(ERR), 512'(tbl[i].err));
            chk("tbl_byte0", 512'(DATA[511:504]), 512'(last_data[7:0]));
            chk("tbl_pkt_cnt", 512'(PKT_CNT), 512'(i + 1));
            chk("tbl_proto", 512'(PROTO_ERR_STICKY), 512'(tbl[i].proto));
        end

        // 150-byte packet over three back-to-back beats.
        send('1, 1'b0);
        send('1, 1'b0);
        send(64'h0000_0000_003F_FFFF, 1'b1);
        @(posedge CLK); #1;
        chk("p150_en", 512'(EN), 512'(4'h3));
        chk("p150_eop", 512'(EOP), 512'(4'h2));
        chk("p150_mty", 512'(MTY), 512'(16'h00A0));
        chk("p150_bubble", 512'(BUBBLE_CNT), 512'(0));

        // Source gap of three cycles inside a packet.
        send('1, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("gap_en", 512'(EN), 512'(0));
        @(posedge CLK); #1;
        send('1, 1'b1);
        @(posedge CLK); #1;
        chk("gap_bubble", 512'(BUBBLE_CNT), 512'(3));
        chk("gap_eop", 512'(EOP), 512'(4'h8));

        // CMAC overflow / underflow pulses.
        OVF = 1'b1;
        @(posedge CLK); #1;
        OVF = 1'b0;
        UNF = 1'b1;
        @(posedge CLK); #1;
        UNF = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("ovf_sticky", 512'(OVF_STICKY), 512'(1));
        chk("unf_sticky", 512'(UNF_STICKY), 512'(1));

        // Backpressure: RDY low for five edges while the source streams.
        RDY = 1'b0;
        fork
            begin
                repeat (2) @(posedge CLK);
                #2;
                chk("bp_tready_full", 512'(TREADY), 512'(0));
                repeat (3) @(posedge CLK);
                #1;
                RDY = 1'b1;
            end
            begin
                send('1, 1'b0);
                send('1, 1'b0);
                send('1, 1'b0);
                send('1, 1'b1);
            end
        join
        repeat (3) @(posedge CLK);
        #1;

        // Reset with two beats buffered mid-packet.
        RDY = 1'b0;
        send('1, 1'b0);
        send('1, 1'b0);
        RST = 1'b1;
        #1;
        chk("rst_en", 512'(EN), 512'(0));
        chk("rst_tready", 512'(TREADY), 512'(0));
        chk("rst_pkt_cnt", 512'(PKT_CNT), 512'(0));
        chk("rst_ovf", 512'(OVF_STICKY), 512'(0));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        RDY = 1'b1;
        #1;
        chk("rst_tready_low", 512'(TREADY), 512'(0));
        send('1, 1'b1);
        @(posedge CLK); #1;
        chk("rst_first_sop", 512'(SOP), 512'(4'h1));
        chk("rst_first_eop", 512'(EOP), 512'(4'h8));
        chk("rst_pkt_after", 512'(PKT_CNT), 512'(1));

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            acc = TVALID && TREADY;
            @(posedge CLK); #1;
            RDY = ($urandom_range(0, 3) != 0);
            OVF = ($urandom_range(0, 199) == 0);
            UNF = ($urandom_range(0, 199) == 0);
            if (acc || !TVALID) begin
                if ($urandom_range(0, 9) < 7) begin
                    TVALID = 1'b1;
                    TDATA  = rand512();
                    TLAST  = ($urandom_range(0, 3) == 0);
                    if (TLAST) begin
                        case ($urandom_range(0, 9))
                            0, 1, 2: TSTRB = '1;
                            3:       TSTRB = '0;
                            4, 5:    TSTRB = {$urandom, $urandom};
                            default: begin
                                int unsigned nb;
                                logic [63:0] ones;
                                ones  = '1;
                                nb    = $urandom_range(1, 64);
                                TSTRB = ones >> (64 - nb);
                            end
                        endcase
                    end else begin
                        TSTRB = ($urandom_range(0, 9) == 0) ? 64'({$urandom, $urandom}) : '1;
                    end
                end else begin
                    TVALID = 1'b0;
                end
            end
        end
        @(negedge CLK);
        acc = TVALID && TREADY;
        @(posedge CLK); #1;
        if (!acc) begin
            RDY = 1'b1;
            for (int c = 0; c < 16 && !acc; c++) begin
                @(negedge CLK); acc = TREADY;
                @(posedge CLK); #1;
            end
        end
        TVALID = 1'b0;
        RDY = 1'b1;
        OVF = 1'b0;
        UNF = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
